// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg7_pkg
// Description : Shared glyph constants, glyph decode function and width
//               helper for the 7-segment scan driver.
// Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    // Active-high glyphs, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] GLYPH_0     = 7'b0111111;
    localparam logic [6:0] GLYPH_1     = 7'b0000110;
    localparam logic [6:0] GLYPH_2     = 7'b1011011;
    localparam logic [6:0] GLYPH_3     = 7'b1001111;
    localparam logic [6:0] GLYPH_4     = 7'b1100110;
    localparam logic [6:0] GLYPH_5     = 7'b1101101;
    localparam logic [6:0] GLYPH_6     = 7'b1111101;
    localparam logic [6:0] GLYPH_7     = 7'b0000111;
    localparam logic [6:0] GLYPH_8     = 7'b1111111;
    localparam logic [6:0] GLYPH_9     = 7'b1101111;
    localparam logic [6:0] GLYPH_A     = 7'b1110111;
    localparam logic [6:0] GLYPH_B     = 7'b1111100;
    localparam logic [6:0] GLYPH_C     = 7'b0111001;
    localparam logic [6:0] GLYPH_D     = 7'b1011110;
    localparam logic [6:0] GLYPH_E     = 7'b1111001;
    localparam logic [6:0] GLYPH_F     = 7'b1110001;
    localparam logic [6:0] GLYPH_BLANK = 7'b0000000;

    // Counter/index width for a modulus n, never less than one bit
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Code to active-high glyph; codes 10..15 go dark when hex is disabled
    function automatic logic [6:0] code_to_glyph(input logic [3:0] code, input logic hex_en);
        logic [6:0] glyph;
        case (code)
            4'd0:    glyph = GLYPH_0;
            4'd1:    glyph = GLYPH_1;
            4'd2:    glyph = GLYPH_2;
            4'd3:    glyph = GLYPH_3;
            4'd4:    glyph = GLYPH_4;
            4'd5:    glyph = GLYPH_5;
            4'd6:    glyph = GLYPH_6;
            4'd7:    glyph = GLYPH_7;
            4'd8:    glyph = GLYPH_8;
            4'd9:    glyph = GLYPH_9;
            4'd10:   glyph = hex_en ? GLYPH_A : GLYPH_BLANK;
            4'd11:   glyph = hex_en ? GLYPH_B : GLYPH_BLANK;
            4'd12:   glyph = hex_en ? GLYPH_C : GLYPH_BLANK;
            4'd13:   glyph = hex_en ? GLYPH_D : GLYPH_BLANK;
            4'd14:   glyph = hex_en ? GLYPH_E : GLYPH_BLANK;
            4'd15:   glyph = hex_en ? GLYPH_F : GLYPH_BLANK;
            default: glyph = GLYPH_BLANK;
        endcase
        return glyph;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_glyph_rom.sv
`default_nettype none
// ============================================================================
// Module      : seg7_glyph_rom
// Description : Combinational 4-bit code to active-high 7-segment glyph.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_glyph_rom
    import seg7_pkg::*;
(
    input  logic [3:0] i_code,
    input  logic       i_hex_en,
    output logic [6:0] o_glyph
);

    // Pure table decode of the selected digit
    always_comb begin
        o_glyph = code_to_glyph(i_code, i_hex_en);
    end

endmodule
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_driver
// Description : Time-multiplexed N-digit 7-segment driver with per-frame
//               input snapshot, hex glyphs, leading-zero suppression,
//               blinking and anode dead time.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 64,
    parameter bit HEX_EN       = 1'b1,
    parameter bit SEG_ACT_LOW  = 1'b1,
    parameter bit AN_ACT_LOW   = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic [NUM_DIGITS-1:0]   blink_in,
    input  logic                    lz_en,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_start
);

    localparam int IDX_W = idx_width(NUM_DIGITS);
    localparam int PRE_W = idx_width(SCAN_DIV);
    localparam int BLK_W = idx_width(BLINK_FRAMES);
    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [PRE_W-1:0] C_LAST_PRE = PRE_W'(SCAN_DIV - 1);
    localparam logic [BLK_W-1:0] C_LAST_BLK = BLK_W'(BLINK_FRAMES - 1);

    logic [PRE_W-1:0]        presc_q, presc_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    started_q, started_d;
    logic [BLK_W-1:0]        blink_cnt_q, blink_cnt_d;
    logic                    blink_off_q, blink_off_d;
    logic [4*NUM_DIGITS-1:0] snap_digits_q, snap_digits_d;
    logic [NUM_DIGITS-1:0]   snap_dp_q, snap_dp_d;
    logic [NUM_DIGITS-1:0]   snap_blank_q, snap_blank_d;
    logic [NUM_DIGITS-1:0]   snap_blink_q, snap_blink_d;
    logic                    snap_lz_q, snap_lz_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    frame_start_q, frame_start_d;

    logic                    w_tick;
    logic                    w_snap_en;
    logic [3:0]              w_sel_code;
    logic                    w_sel_dp, w_sel_blank, w_sel_blink, w_sel_lz;
    logic [NUM_DIGITS-1:0]   w_sel_onehot;
    logic [NUM_DIGITS-1:0]   w_lz_mask;
    logic                    w_zero_run;
    logic [6:0]              w_glyph, w_lit_seg;
    logic                    w_lit_dp;
    logic [NUM_DIGITS-1:0]   w_an_lit;

    // Timebase, digit index, frame snapshot and blink phase next-state
    always_comb begin
        w_tick        = (presc_q == C_LAST_PRE);
        presc_d       = w_tick ? '0 : presc_q + PRE_W'(1);
        idx_d         = idx_q;
        if (w_tick) begin
            idx_d = (idx_q == C_LAST_IDX) ? '0 : idx_q + IDX_W'(1);
        end
        // The very first tick also snapshots so real data appears quickly
        w_snap_en     = w_tick && ((idx_d == '0) || !started_q);
        started_d     = started_q || w_tick;
        snap_digits_d = snap_digits_q;
        snap_dp_d     = snap_dp_q;
        snap_blank_d  = snap_blank_q;
        snap_blink_d  = snap_blink_q;
        snap_lz_d     = snap_lz_q;
        blink_cnt_d   = blink_cnt_q;
        blink_off_d   = blink_off_q;
        if (w_snap_en) begin
            snap_digits_d = digits_in;
            snap_dp_d     = dp_in;
            snap_blank_d  = blank_in;
            snap_blink_d  = blink_in;
            snap_lz_d     = lz_en;
            if (blink_cnt_q == C_LAST_BLK) begin
                blink_cnt_d = '0;
                blink_off_d = ~blink_off_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BLK_W'(1);
            end
        end
    end

    // Select the digit being driven next and work out leading-zero darkening
    always_comb begin
        w_sel_code   = 4'd0;
        w_sel_dp     = 1'b0;
        w_sel_blank  = 1'b0;
        w_sel_blink  = 1'b0;
        w_sel_lz     = 1'b0;
        w_sel_onehot = '0;
        w_lz_mask    = '0;
        w_zero_run   = snap_lz_d;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_zero_run   = w_zero_run && (snap_digits_d[4*i +: 4] == 4'd0);
            w_lz_mask[i] = w_zero_run && (i != 0);
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_d == IDX_W'(i)) begin
                w_sel_code      = snap_digits_d[4*i +: 4];
                w_sel_dp        = snap_dp_d[i];
                w_sel_blank     = snap_blank_d[i];
                w_sel_blink     = snap_blink_d[i];
                w_sel_lz        = w_lz_mask[i];
                w_sel_onehot[i] = 1'b1;
            end
        end
    end

    seg7_glyph_rom u_glyph_rom (
        .i_code   (w_sel_code),
        .i_hex_en (HEX_EN),
        .o_glyph  (w_glyph)
    );

    // Apply blank > blink-off > leading-zero precedence, dead time, polarity
    always_comb begin
        w_lit_seg = w_glyph;
        w_lit_dp  = w_sel_dp;
        if (w_sel_blank || (blink_off_d && w_sel_blink)) begin
            w_lit_seg = GLYPH_BLANK;
            w_lit_dp  = 1'b0;
        end else if (w_sel_lz) begin
            w_lit_seg = GLYPH_BLANK;
        end
        // Anodes go dark for one cycle on every scan step to avoid ghosting
        w_an_lit      = w_tick ? '0 : w_sel_onehot;
        seg_d         = SEG_ACT_LOW ? ~w_lit_seg : w_lit_seg;
        dp_d          = SEG_ACT_LOW ? ~w_lit_dp : w_lit_dp;
        an_d          = AN_ACT_LOW ? ~w_an_lit : w_an_lit;
        frame_start_d = w_snap_en;
    end

    // State and registered outputs with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q       <= '0;
            idx_q         <= '0;
            started_q     <= 1'b0;
            blink_cnt_q   <= '0;
            blink_off_q   <= 1'b0;
            snap_digits_q <= '0;
            snap_dp_q     <= '0;
            snap_blank_q  <= '0;
            snap_blink_q  <= '0;
            snap_lz_q     <= 1'b0;
            seg_q         <= {7{SEG_ACT_LOW}};
            dp_q          <= SEG_ACT_LOW;
            an_q          <= {NUM_DIGITS{AN_ACT_LOW}};
            frame_start_q <= 1'b0;
        end else begin
            presc_q       <= presc_d;
            idx_q         <= idx_d;
            started_q     <= started_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_off_q   <= blink_off_d;
            snap_digits_q <= snap_digits_d;
            snap_dp_q     <= snap_dp_d;
            snap_blank_q  <= snap_blank_d;
            snap_blink_q  <= snap_blink_d;
            snap_lz_q     <= snap_lz_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            an_q          <= an_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign seg         = seg_q;
    assign dp          = dp_q;
    assign an          = an_q;
    assign frame_start = frame_start_q;

endmodule
`default_nettype wire
